// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART frame decoder: state encodings and defaults.
package uart_frame_decoder_pkg;

  localparam int unsigned UART_MAX_LEN_DEFAULT   = 16;
  localparam logic [7:0]  UART_SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_EMIT    = 3'd5
  } state_e;

  // Width of a counter able to hold values 0..limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_decoder_buf.sv
// Payload buffer: DEPTH x 8, one synchronous write port, one asynchronous read port.
module frame_buf #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Address decode by comparison keeps out-of-range addresses harmless.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (we_i && (waddr_i == 8'(k))) begin
        mem_q[k] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (raddr_i == 8'(k)) begin
        rdata_o = mem_q[k];
      end
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/CMD/LEN/payload/CHK frames from a UART byte stream and replays
// the checked payload through a valid/ready byte interface.
module uart_frame_decoder
  import uart_frame_decoder_pkg::*;
#(
  parameter int unsigned MAX_LEN        = UART_MAX_LEN_DEFAULT,
  parameter logic [7:0]  SYNC_BYTE      = UART_SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 14000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_byte_last,
  output logic       o_frame_done,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_overrun,
  input  logic       i_clr_overrun,
  output logic       o_busy,
  output logic [2:0] o_state_debug
);

  localparam int unsigned TW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [7:0]    cmd_q;
  logic [7:0]    len_q;
  logic [7:0]    idx_q;
  logic [7:0]    xor_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    byte_q;
  logic          byte_valid_q;
  logic          byte_last_q;
  logic          done_q;
  logic          err_chk_q;
  logic          err_len_q;
  logic          err_tmo_q;
  logic          overrun_q;

  logic          buf_we_d;
  logic [7:0]    rd_idx_d;
  logic [7:0]    rd_data_d;
  logic          in_frame_d;
  logic          tmo_hit_d;

  assign buf_we_d   = (state_q == ST_PAYLOAD) && i_data_valid;
  // In EMIT the read port looks one byte ahead so the next byte is ready on acceptance.
  assign rd_idx_d   = (state_q == ST_EMIT) ? (idx_q + 8'd1) : 8'd0;
  assign in_frame_d = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign tmo_hit_d  = (tmo_q == TMO_LAST);

  frame_buf #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk_i   (i_clk),
    .we_i    (buf_we_d),
    .waddr_i (idx_q),
    .wdata_i (i_data),
    .raddr_i (rd_idx_d),
    .rdata_o (rd_data_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_HUNT;
      cmd_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      xor_q        <= '0;
      tmo_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_chk_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;

      if (i_data_valid && (state_q == ST_EMIT)) begin
        overrun_q <= 1'b1;
      end else if (i_clr_overrun) begin
        overrun_q <= 1'b0;
      end

      if (i_data_valid || !in_frame_d) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end

      if (in_frame_d && !i_data_valid && tmo_hit_d) begin
        err_tmo_q <= 1'b1;
        state_q   <= ST_HUNT;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (i_data_valid && (i_data == SYNC_BYTE)) begin
              state_q <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (i_data_valid) begin
              cmd_q   <= i_data;
              xor_q   <= i_data;
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_data_valid) begin
              if (i_data > MAX_LEN8) begin
                err_len_q <= 1'b1;
                state_q   <= ST_HUNT;
              end else begin
                len_q   <= i_data;
                xor_q   <= xor_q ^ i_data;
                idx_q   <= '0;
                state_q <= (i_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (i_data_valid) begin
              xor_q <= xor_q ^ i_data;
              idx_q <= idx_q + 8'd1;
              if ((idx_q + 8'd1) == len_q) begin
                state_q <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (i_data_valid) begin
              if (i_data == xor_q) begin
                state_q      <= ST_EMIT;
                idx_q        <= '0;
                byte_valid_q <= (len_q != 8'd0);
                byte_q       <= (len_q != 8'd0) ? rd_data_d : 8'd0;
                byte_last_q  <= (len_q == 8'd1);
              end else begin
                err_chk_q <= 1'b1;
                state_q   <= ST_HUNT;
              end
            end
          end
          ST_EMIT: begin
            if (!byte_valid_q) begin
              done_q  <= 1'b1;
              state_q <= ST_HUNT;
            end else if (i_byte_ready) begin
              if (byte_last_q) begin
                byte_valid_q <= 1'b0;
                byte_last_q  <= 1'b0;
                byte_q       <= '0;
                done_q       <= 1'b1;
                state_q      <= ST_HUNT;
              end else begin
                idx_q       <= idx_q + 8'd1;
                byte_q      <= rd_data_d;
                byte_last_q <= ((idx_q + 8'd2) == len_q);
              end
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign o_cmd         = cmd_q;
  assign o_len         = len_q;
  assign o_byte        = byte_q;
  assign o_byte_valid  = byte_valid_q;
  assign o_byte_last   = byte_last_q;
  assign o_frame_done  = done_q;
  assign o_err_chk     = err_chk_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_tmo_q;
  assign o_overrun     = overrun_q;
  assign o_busy        = (state_q != ST_HUNT);
  assign o_state_debug = state_q;

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 14000, maximum i_clk cycles allowed between bytes inside a frame.
REQ-004 i_clk  in  1  clock; reset i_rst, synchronous, active-high.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_data  in  8  received byte from the UART receiver.
REQ-007 i_data_valid  in  1  single-cycle strobe; i_data valid this cycle.
REQ-008 o_cmd  out  8  command byte of the frame being emitted.
REQ-009 o_len  out  8  payload length of the frame being emitted.
REQ-010 o_byte  out  8  payload byte.
REQ-011 o_byte_valid  out  1  o_byte valid; held until accepted.
REQ-012 i_byte_ready  in  1  consumer accepts o_byte when high with o_byte_valid.
REQ-013 o_byte_last  out  1  high with the final payload byte.
REQ-014 o_frame_done  out  1  one-cycle pulse after a frame fully emitted (also for LEN=0).
REQ-015 o_err_chk / o_err_len / o_err_timeout  out  1 each  one-cycle error pulses.
REQ-016 o_overrun  out  1  sticky: a byte arrived while in EMIT; cleared by i_clr_overrun.
REQ-017 i_clr_overrun  in  1  clears o_overrun.
REQ-018 o_busy  out  1  high in any state except HUNT.
REQ-019 o_state_debug  out  3  current state encoding.

Function
REQ-020 Frame format SHALL be SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-021 States SHALL be HUNT=0, CMD=1, LEN=2, PAYLOAD=3, CHECK=4, EMIT=5; others return to HUNT.
REQ-022 HUNT: byte == SYNC_BYTE -> CMD; other bytes discarded silently.
REQ-023 CMD: store byte, init running XOR to it -> LEN.
REQ-024 LEN: byte > MAX_LEN -> pulse o_err_len, HUNT; byte == 0 -> CHECK; else -> PAYLOAD, write index 0.
REQ-025 PAYLOAD: each byte written to buffer[index], XORed in; after LEN-th byte -> CHECK.
REQ-026 CHECK: byte == running XOR -> EMIT, read index 0; mismatch -> pulse o_err_chk, HUNT.
REQ-027 EMIT: o_byte_valid high while read index < LEN; byte advances only on valid&&ready; o_byte_last when index == LEN-1.
REQ-028 EMIT SHALL pulse o_frame_done the cycle after the last accepted byte (or the cycle after entering EMIT when LEN=0), then -> HUNT.
REQ-029 o_cmd and o_len SHALL be stable throughout EMIT.
REQ-030 Byte strobe while in EMIT SHALL be dropped and set o_overrun; set has priority over simultaneous i_clr_overrun.
REQ-031 Inter-byte counter SHALL reset on each accepted strobe; in CMD/LEN/PAYLOAD/CHECK, reaching TIMEOUT_CYCLES-1 without a strobe -> pulse o_err_timeout, HUNT.
REQ-032 SYNC_BYTE value appearing inside CMD/LEN/PAYLOAD/CHECK SHALL be treated as data, not resync.
REQ-033 Strobe consumption latency: state update visible one cycle after i_data_valid.

Reset
REQ-034 Reset SHALL force HUNT, all indices/counters/XOR to 0, o_byte_valid/o_byte_last/o_frame_done/error pulses/o_overrun to 0, o_cmd/o_len/o_byte to 8'h00.
REQ-035 Reset mid-frame or mid-EMIT SHALL abandon the frame with no o_frame_done or error pulse.

Structure
REQ-036 State encodings, SYNC_BYTE default and MAX_LEN default SHALL live in a shared uart package.
REQ-037 Payload buffer SHALL be a sub-module frame_buf (MAX_LEN x 8, 1 write port, 1 async read port).

Verification
REQ-038 A5 10 02 33 44 CHK=65 -> o_cmd=10, o_len=02, bytes 33,44 (last on 44), one o_frame_done.
REQ-039 A5 10 02 33 44 00 -> o_err_chk pulse, no o_byte_valid, state HUNT.
REQ-040 A5 01 11 (MAX_LEN=16) -> o_err_len pulse, back to HUNT; following A5 07 00 07 -> o_frame_done, no payload.
REQ-041 A5 10 then silence TIMEOUT_CYCLES -> o_err_timeout pulse, HUNT; subsequent valid frame decodes.
REQ-042 i_byte_ready low 10 cycles during EMIT plus one strobe -> o_byte held stable, o_overrun=1 until i_clr_overrun.
REQ-043 i_rst asserted mid-PAYLOAD -> all outputs reset values next cycle, no done/error pulse.
